// File: rtl/axi_decerr_slave_pkg.sv
// Shared constants and types for the ExtIO decode-error responder.
// Mirrors the ariane_soc constants this block depends on:
//   IdWidthSlave - AXI ID width seen by slaves behind the I/O demux
//   DecErrResp   - AXI DECERR response code
//   ExtLast      - demux port index the responder is attached to
package axi_decerr_slave_pkg;

  localparam int unsigned IdWidthSlave = 5;
  localparam int unsigned ExtLast      = 6;

  localparam logic [1:0] OkayResp   = 2'b00;
  localparam logic [1:0] DecErrResp = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

endpackage

// File: rtl/axi_decerr_rd_burst.sv
// Read half of the decode-error responder: accepts one AR at a time and
// returns ar_len+1 DECERR beats carrying a fixed data pattern.
// Ports:
//   clk_i, rst_i               clock, asynchronous active-high reset
//   ar_valid_i/ar_ready_o      read-address handshake
//   ar_id_i, ar_len_i          ID to echo and burst length
//   r_valid_o/r_ready_i        read-data handshake
//   r_id_o, r_data_o, r_resp_o, r_last_o  read-data payload
module axi_decerr_rd_burst
  import axi_decerr_slave_pkg::*;
#(
  parameter int unsigned          IdWidth   = IdWidthSlave,
  parameter int unsigned          DataWidth = 64,
  parameter logic [DataWidth-1:0] RdPattern = 64'hBADC_AB1E_BADC_AB1E
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 ar_valid_i,
  output logic                 ar_ready_o,
  input  logic [IdWidth-1:0]   ar_id_i,
  input  logic [7:0]           ar_len_i,
  output logic                 r_valid_o,
  input  logic                 r_ready_i,
  output logic [IdWidth-1:0]   r_id_o,
  output logic [DataWidth-1:0] r_data_o,
  output logic [1:0]           r_resp_o,
  output logic                 r_last_o
);

  rd_state_e              state_reg;
  logic [7:0]             cnt_reg;      // beats remaining after the current one
  logic                   ar_ready_reg;
  logic                   r_valid_reg;
  logic [IdWidth-1:0]     r_id_reg;
  logic [DataWidth-1:0]   r_data_reg;
  logic [1:0]             r_resp_reg;
  logic                   r_last_reg;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg    <= R_IDLE;
      cnt_reg      <= 8'd0;
      ar_ready_reg <= 1'b0;
      r_valid_reg  <= 1'b0;
      r_id_reg     <= '0;
      r_data_reg   <= '0;
      r_resp_reg   <= OkayResp;
      r_last_reg   <= 1'b0;
    end else begin
      unique case (state_reg)
        R_IDLE: begin
          // ready comes up one cycle after reset release and stays up
          ar_ready_reg <= 1'b1;
          if (ar_valid_i && ar_ready_reg) begin
            ar_ready_reg <= 1'b0;
            cnt_reg      <= ar_len_i;
            r_valid_reg  <= 1'b1;
            r_id_reg     <= ar_id_i;
            r_data_reg   <= RdPattern;
            r_resp_reg   <= DecErrResp;
            r_last_reg   <= (ar_len_i == 8'd0);
            state_reg    <= R_DATA;
          end
        end
        R_DATA: begin
          if (r_ready_i) begin
            if (cnt_reg == 8'd0) begin
              r_valid_reg  <= 1'b0;
              r_last_reg   <= 1'b0;
              ar_ready_reg <= 1'b1;
              state_reg    <= R_IDLE;
            end else begin
              // counting down to zero means len=255 gives 256 beats, no wrap
              cnt_reg    <= cnt_reg - 8'd1;
              r_last_reg <= (cnt_reg == 8'd1);
            end
          end
        end
        default: state_reg <= R_IDLE;
      endcase
    end
  end

  assign ar_ready_o = ar_ready_reg;
  assign r_valid_o  = r_valid_reg;
  assign r_id_o     = r_id_reg;
  assign r_data_o   = r_data_reg;
  assign r_resp_o   = r_resp_reg;
  assign r_last_o   = r_last_reg;

endmodule

// File: rtl/axi_decerr_slave.sv
// AXI4 responder for unmapped holes of the ExtIO window. Every burst is
// completed with DECERR so the core takes an access fault instead of
// hanging; the first faulting address is held for software and every
// accepted AW/AR produces a one-cycle interrupt pulse.
// Ports:
//   clk_i, rst_i                      clock, asynchronous active-high reset
//   aw_*, w_*, b_*                    AXI write channels (W data discarded)
//   ar_*, r_*                         AXI read channels
//   err_clr_i                         clears the sticky capture
//   err_valid_o, err_addr_o, err_we_o captured fault (sticky)
//   err_irq_o                         one-cycle pulse per accepted AW/AR
module axi_decerr_slave
  import axi_decerr_slave_pkg::*;
#(
  parameter int unsigned          IdWidth   = IdWidthSlave,
  parameter int unsigned          AddrWidth = 64,
  parameter int unsigned          DataWidth = 64,
  parameter logic [DataWidth-1:0] RdPattern = 64'hBADC_AB1E_BADC_AB1E
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 aw_valid_i,
  output logic                 aw_ready_o,
  input  logic [IdWidth-1:0]   aw_id_i,
  input  logic [AddrWidth-1:0] aw_addr_i,
  input  logic [7:0]           aw_len_i,
  input  logic                 w_valid_i,
  output logic                 w_ready_o,
  input  logic                 w_last_i,
  output logic                 b_valid_o,
  input  logic                 b_ready_i,
  output logic [IdWidth-1:0]   b_id_o,
  output logic [1:0]           b_resp_o,
  input  logic                 ar_valid_i,
  output logic                 ar_ready_o,
  input  logic [IdWidth-1:0]   ar_id_i,
  input  logic [AddrWidth-1:0] ar_addr_i,
  input  logic [7:0]           ar_len_i,
  output logic                 r_valid_o,
  input  logic                 r_ready_i,
  output logic [IdWidth-1:0]   r_id_o,
  output logic [DataWidth-1:0] r_data_o,
  output logic [1:0]           r_resp_o,
  output logic                 r_last_o,
  input  logic                 err_clr_i,
  output logic                 err_valid_o,
  output logic [AddrWidth-1:0] err_addr_o,
  output logic                 err_we_o,
  output logic                 err_irq_o
);

  wr_state_e            w_state_reg;
  logic                 aw_ready_reg;
  logic                 w_ready_reg;
  logic                 b_valid_reg;
  logic [IdWidth-1:0]   b_id_reg;
  logic [1:0]           b_resp_reg;

  logic                 err_valid_reg;
  logic [AddrWidth-1:0] err_addr_reg;
  logic                 err_we_reg;
  logic                 err_irq_reg;

  logic                 aw_hs;
  logic                 ar_hs;
  logic                 ar_ready_int;

  // The write burst is drained on WLAST, so the AW length carries no meaning here.
  logic                 aw_len_unused;
  assign aw_len_unused = ^aw_len_i;

  assign aw_hs = aw_valid_i & aw_ready_reg;
  assign ar_hs = ar_valid_i & ar_ready_int;

  // Write FSM: accept AW, swallow W up to WLAST, answer with one DECERR B.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      w_state_reg  <= W_IDLE;
      aw_ready_reg <= 1'b0;
      w_ready_reg  <= 1'b0;
      b_valid_reg  <= 1'b0;
      b_id_reg     <= '0;
      b_resp_reg   <= OkayResp;
    end else begin
      unique case (w_state_reg)
        W_IDLE: begin
          aw_ready_reg <= 1'b1;
          if (aw_hs) begin
            aw_ready_reg <= 1'b0;
            w_ready_reg  <= 1'b1;
            b_id_reg     <= aw_id_i;
            w_state_reg  <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_valid_i && w_ready_reg && w_last_i) begin
            w_ready_reg <= 1'b0;
            b_valid_reg <= 1'b1;
            b_resp_reg  <= DecErrResp;
            w_state_reg <= W_RESP;
          end
        end
        W_RESP: begin
          if (b_ready_i) begin
            b_valid_reg  <= 1'b0;
            aw_ready_reg <= 1'b1;
            w_state_reg  <= W_IDLE;
          end
        end
        default: w_state_reg <= W_IDLE;
      endcase
    end
  end

  // Sticky first-fault capture. A handshake in the clear cycle re-arms the
  // capture with the new fault; on a simultaneous AW/AR the write is kept.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_valid_reg <= 1'b0;
      err_addr_reg  <= '0;
      err_we_reg    <= 1'b0;
      err_irq_reg   <= 1'b0;
    end else begin
      err_irq_reg <= aw_hs | ar_hs;
      if ((aw_hs || ar_hs) && (!err_valid_reg || err_clr_i)) begin
        err_valid_reg <= 1'b1;
        err_we_reg    <= aw_hs;
        err_addr_reg  <= aw_hs ? aw_addr_i : ar_addr_i;
      end else if (err_clr_i) begin
        err_valid_reg <= 1'b0;
      end
    end
  end

  axi_decerr_rd_burst #(
    .IdWidth   (IdWidth),
    .DataWidth (DataWidth),
    .RdPattern (RdPattern)
  ) u_rd (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .ar_valid_i (ar_valid_i),
    .ar_ready_o (ar_ready_int),
    .ar_id_i    (ar_id_i),
    .ar_len_i   (ar_len_i),
    .r_valid_o  (r_valid_o),
    .r_ready_i  (r_ready_i),
    .r_id_o     (r_id_o),
    .r_data_o   (r_data_o),
    .r_resp_o   (r_resp_o),
    .r_last_o   (r_last_o)
  );

  assign aw_ready_o  = aw_ready_reg;
  assign w_ready_o   = w_ready_reg;
  assign b_valid_o   = b_valid_reg;
  assign b_id_o      = b_id_reg;
  assign b_resp_o    = b_resp_reg;
  assign ar_ready_o  = ar_ready_int;
  assign err_valid_o = err_valid_reg;
  assign err_addr_o  = err_addr_reg;
  assign err_we_o    = err_we_reg;
  assign err_irq_o   = err_irq_reg;

endmodule

// File: doc/axi_decerr_slave.md
Name: axi_decerr_slave

Overview:
- AXI4 responder that terminates every transaction routed to unmapped holes in the ExtIO window (0x4000_0000–0x4FFF_FFFF, outside the BOOT/UART/SPI/Ethernet/GPIO/HID apertures).
- Attached to the ExtLast port of the I/O demux.
- Completes all bursts protocol-correctly with DECERR, so the core takes an access fault instead of hanging.
- Records the first faulting address and raises a one-cycle interrupt pulse toward a PLIC source.

Parameters:
- IdWidth, 5 (ariane_soc::IdWidthSlave), AXI ID width.
- AddrWidth, 64, AXI address width.
- DataWidth, 64, AXI data width.
- RdPattern, 64'hBADC_AB1E_BADC_AB1E, RDATA value on error beats.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- aw_valid_i/aw_ready_o  in/out  1  write-address handshake
- aw_id_i  in  IdWidth  write ID
- aw_addr_i  in  AddrWidth  write address
- aw_len_i  in  8  write burst length (ignored; W drained until WLAST)
- w_valid_i/w_ready_o  in/out  1  write-data handshake
- w_last_i  in  1  last write beat
- b_valid_o/b_ready_i  out/in  1  write-response handshake
- b_id_o  out  IdWidth  BID
- b_resp_o  out  2  BRESP
- ar_valid_i/ar_ready_o  in/out  1  read-address handshake
- ar_id_i  in  IdWidth  read ID
- ar_addr_i  in  AddrWidth  read address
- ar_len_i  in  8  read burst length
- r_valid_o/r_ready_i  out/in  1  read-data handshake
- r_id_o  out  IdWidth  RID
- r_data_o  out  DataWidth  RDATA
- r_resp_o  out  2  RRESP
- r_last_o  out  1  RLAST
- err_clr_i  in  1  clears the sticky error capture
- err_valid_o  out  1  sticky: a fault was captured
- err_addr_o  out  AddrWidth  first faulting address
- err_we_o  out  1  1 = captured fault was a write
- err_irq_o  out  1  one-cycle pulse per accepted faulting AW/AR

Behaviour:
- Reset (asynchronous, rst_i=1):
  - All valid/ready outputs 0.
  - b_id_o, r_id_o, r_data_o 0; b_resp_o, r_resp_o 2'b00; r_last_o 0.
  - err_valid_o 0, err_addr_o 0, err_we_o 0, err_irq_o 0.
  - Both FSMs return to IDLE; an in-flight burst is abandoned.
- Write FSM: W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: aw_ready_o=1. On AW handshake, latch aw_id_i -> W_DATA.
  - W_DATA: w_ready_o=1, data discarded. On W handshake with w_last_i=1 -> W_RESP.
  - W_RESP: b_valid_o=1, b_resp_o=2'b11, b_id_o=latched ID. Hold until b_ready_i, then -> W_IDLE.
  - W beats arriving before AW are not accepted: w_ready_o=0 outside W_DATA.
- Read FSM: R_IDLE -> R_DATA -> R_IDLE.
  - R_IDLE: ar_ready_o=1. On AR handshake, latch ar_id_i; load 8-bit beat counter cnt=ar_len_i; -> R_DATA.
  - R_DATA: r_valid_o=1, r_resp_o=2'b11, r_data_o=RdPattern, r_id_o=latched ID, r_last_o=(cnt==0).
  - On each R handshake: if cnt==0 -> R_IDLE, else cnt-1.
  - len=255 yields exactly 256 beats; the counter never wraps.
- Timing:
  - First R beat and W ready are asserted the cycle after the address handshake.
  - B is asserted the cycle after the WLAST handshake.
  - Back-to-back: aw_ready/ar_ready return the cycle after the B/final-R handshake. One outstanding transaction per channel; read and write channels are fully independent.
  - Valid outputs and their payloads are stable while ready is low (AXI rule).
- Error capture:
  - err_irq_o pulses for one cycle on every AW or AR handshake.
  - If err_valid_o=0: capture the address and err_we_o, and set err_valid_o. Further faults do not overwrite.
  - Simultaneous AW and AR handshake with err_valid_o=0: the write wins (err_we_o=1); err_irq_o is still a single pulse.
  - err_clr_i clears err_valid_o. If a handshake occurs in the same cycle as err_clr_i, the new capture wins: err_valid_o stays 1 with the new address.

Decomposition:
- ariane_soc package: DecErrResp=2'b11 constant; ExtLast index used for the demux hookup.
- Sub-module axi_decerr_rd_burst: read FSM plus beat counter.
- Write FSM and error capture stay in the top module.

Test Plan:
- Write: AW id=5'h03, addr=0x4600_0000, len=3; 4 W beats, WLAST on the 4th.
  -> BID=3, BRESP=2'b11 one cycle after WLAST.
  -> err_addr_o=0x4600_0000, err_we_o=1, err_valid_o=1, single err_irq_o pulse.
- Read: AR id=5'h11, len=7, r_ready_i toggled every other cycle.
  -> exactly 8 beats, RID=0x11, RRESP=2'b11, RDATA=RdPattern, RLAST only on beat 8, payload stable during stalls.
- Max burst: AR len=255 -> exactly 256 beats, no extra beat, ar_ready_o=1 the cycle after the last handshake.
- Simultaneous AW (addr 0x4700_0000) and AR (addr 0x4800_0000) after clear.
  -> err_addr_o=0x4700_0000, err_we_o=1.
  -> a second fault does not change err_addr_o until err_clr_i.
  -> both B and R responses complete.
- Reset asserted mid read burst (after beat 3 of 8).
  -> r_valid_o=0 immediately.
  -> after release, ar_ready_o=1 and a new AR returns its full burst.
- W beats presented before AW -> w_ready_o=0 until the AW handshake; no B issued early.
